controle_determinante: RTL and testbench
========================================

Name: controle_determinante

Overview:
Multi-cycle controller that computes 2x2 and 3x3 determinants. It accepts a request with a start/busy/done handshake and schedules every product through one shared signed multiplier, so a full combinational determinant array is not needed. It sits in front of the ULA matrix path, uses the same packed 200-bit matriz bus and the same tamanho_matriz encoding, and reports an 8-bit signed det with an overflow flag.

Parameters:
ELEM_W, 8, signed element width; also the width of det.
ACC_W, 32, signed accumulator/product width; must be >= 3*ELEM_W+3.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only while busy=0
matriz  in  200  packed matrix, row-major, first element in the MSBs of the used field
tamanho_matriz  in  2  00=2x2, 01=3x3, 10/11=unsupported
busy  out  1  computation in progress
done  out  1  one-cycle result strobe
det  out  ELEM_W  signed determinant (low ELEM_W bits of the exact value)
overflow_flag  out  1  exact determinant outside [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]
erro  out  1  last request had an unsupported size

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, det, overflow_flag and erro all 0; accumulator and product register cleared.
- Reset asserted mid-operation aborts the computation; no done is produced.
- Element layout, 2x2: a=[31:24], b=[23:16], c=[15:8], d=[7:0].
- Element layout, 3x3: a..i = [71:64] down to [7:0], row-major. All higher bits are ignored.
- Accept: start=1 && busy=0 at edge N. The matrix and size are latched, so later input changes have no effect.
- start while busy=1 is ignored and is not queued.
- States:
  - IDLE -> CALC on accept with a valid size.
  - IDLE -> ERR on accept with size 10/11.
  - CALC -> FIN after the last step.
  - FIN -> IDLE.
  - ERR -> IDLE.
- busy=1 in every CALC cycle and 0 otherwise.
- 2x2 schedule, one multiply per CALC cycle, 2 steps:
  - step 1: acc = a*d
  - step 2: acc = acc - b*c
- 3x3 schedule, Sarrus, 6 terms of 2 steps each (12 steps):
  - step A: p = x*y
  - step B: acc = acc ± p*z
  - Term order: +aei, +bfg, +cdh, -ceg, -afh, -bdi. acc is cleared at accept.
- FIN registers the outputs: det = acc[ELEM_W-1:0]; overflow_flag = range check on the full acc; erro=0; done=1 for exactly one cycle.
- Latency: done is high in cycle N+3 for 2x2 and N+13 for 3x3.
- ERR: done=1 and erro=1 in cycle N+1; det=0; overflow_flag=0.
- det, overflow_flag and erro hold their values until the next done.
- A new start may be accepted in the done cycle, since busy=0 there.
- All arithmetic is signed at full ACC_W width, with sign extension from ELEM_W. The accumulator never wraps for ELEM_W=8.

Optional Feature:
Macro DET_SATURATE_EN.
- Defined: on overflow, det saturates to 127 (positive) or -128 (negative). overflow_flag is still set.
- Undefined: det is the truncated low ELEM_W bits, i.e. two's-complement wrap.

Test Plan:
- Reset mid-run: start a 3x3 request, pull rst_n low at N+5 -> all outputs 0 immediately; no done follows; a new start after release works normally.
- 2x2 wrap: {100,50,30,60}, size 00 -> done at N+3, exact 4500, overflow_flag=1, det=-108 (wrap) or 127 with DET_SATURATE_EN.
- 2x2 negative overflow: {-100,100,100,100} -> exact -20000, overflow_flag=1, det=-32 (wrap) or -128 (saturate).
- 3x3 results:
  - {1,2,3,4,5,6,7,8,9}, size 01 -> done at N+13, det=0, overflow_flag=0.
  - {-1,2,3,4,5,6,7,8,10} -> det=-7.
  - A 2x2 request {3,1,2,4} issued in that done cycle -> det=10 three cycles later.
- Unsupported size: size 10 -> done and erro=1 at N+1, det=0, busy never asserts; a following valid request clears erro.
- Start ignored while busy: pulse start with different data at N+4 of a 3x3 run -> ignored; exactly one done at N+13 carrying the original result; matriz changes during busy do not affect it.

Source files
------------

// File: rtl/controle_determinante.sv
// Multi-cycle 2x2/3x3 determinant controller sharing one signed multiplier (Sarrus for 3x3).
// Optional macro DET_SATURATE_EN clamps det on overflow instead of wrapping.
module controle_determinante #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [199:0]      matriz,
    input  logic [1:0]        tamanho_matriz,
    output logic              busy,
    output logic              done,
    output logic [ELEM_W-1:0] det,
    output logic              overflow_flag,
    output logic              erro,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2, ERR = 2'd3} state_t;

    localparam logic signed [ACC_W-1:0] DET_MAX = ACC_W'((1 << (ELEM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] DET_MIN = ACC_W'(-(1 << (ELEM_W - 1)));

    state_t                  state_q;
    logic [3:0]              step_q;
    logic                    is3_q;
    logic [ELEM_W-1:0]       elem_q [9];
    logic signed [ACC_W-1:0] acc_q, p_q;
    logic                    busy_q, done_q, ovf_q, erro_q;
    logic [ELEM_W-1:0]       det_q;

    logic signed [ACC_W-1:0] mul_a, mul_b, mul, acc_d, p_d;
    logic [3:0]              ix, iy, iz;
    logic                    neg, last_step, ovf_d, size_ok, size_3;
    logic [ELEM_W-1:0]       det_d;
    logic [ELEM_W-1:0]       elem_in [9];
    logic                    unused_matriz;

    function automatic logic signed [ACC_W-1:0] sext(input logic [ELEM_W-1:0] v);
        return {{(ACC_W - ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

    assign size_3        = (tamanho_matriz == 2'b01);
    assign size_ok       = !tamanho_matriz[1];
    assign unused_matriz = ^matriz[199:9*ELEM_W];

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            elem_in[k] = size_3 ? matriz[(8 - k)*ELEM_W +: ELEM_W] : '0;
        end
        for (int k = 0; k < 4; k++) begin
            if (!size_3) elem_in[k] = matriz[(3 - k)*ELEM_W +: ELEM_W];
        end
    end

    // Sarrus term for the current step pair: x*y first, then times z with sign.
    always_comb begin
        ix = 4'd0; iy = 4'd4; iz = 4'd8; neg = 1'b0;
        case (step_q[3:1])
            3'd0:    begin ix = 4'd0; iy = 4'd4; iz = 4'd8; neg = 1'b0; end
            3'd1:    begin ix = 4'd1; iy = 4'd5; iz = 4'd6; neg = 1'b0; end
            3'd2:    begin ix = 4'd2; iy = 4'd3; iz = 4'd7; neg = 1'b0; end
            3'd3:    begin ix = 4'd2; iy = 4'd4; iz = 4'd6; neg = 1'b1; end
            3'd4:    begin ix = 4'd0; iy = 4'd5; iz = 4'd7; neg = 1'b1; end
            default: begin ix = 4'd1; iy = 4'd3; iz = 4'd8; neg = 1'b1; end
        endcase

        if (is3_q) begin
            if (step_q[0]) begin
                mul_a = p_q;
                mul_b = sext(elem_q[iz]);
            end else begin
                mul_a = sext(elem_q[ix]);
                mul_b = sext(elem_q[iy]);
            end
        end else if (step_q[0]) begin
            mul_a = sext(elem_q[1]);
            mul_b = sext(elem_q[2]);
        end else begin
            mul_a = sext(elem_q[0]);
            mul_b = sext(elem_q[3]);
        end
        mul = mul_a * mul_b;

        acc_d = acc_q;
        p_d   = p_q;
        if (is3_q) begin
            if (step_q[0]) acc_d = neg ? acc_q - mul : acc_q + mul;
            else           p_d   = mul;
        end else begin
            acc_d = step_q[0] ? acc_q - mul : mul;
        end

        last_step = is3_q ? (step_q == 4'd11) : (step_q == 4'd1);
        ovf_d     = (acc_d > DET_MAX) || (acc_d < DET_MIN);
`ifdef DET_SATURATE_EN
        if (ovf_d) det_d = acc_d[ACC_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
        else       det_d = acc_d[ELEM_W-1:0];
`else
        det_d = acc_d[ELEM_W-1:0];
`endif
    end

    // Handshake: start is taken on any edge where busy is low (IDLE, FIN or ERR);
    // while busy is high it is dropped, never queued. done pulses once per request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            is3_q   <= 1'b0;
            acc_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            det_q   <= '0;
            ovf_q   <= 1'b0;
            erro_q  <= 1'b0;
            for (int k = 0; k < 9; k++) elem_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CALC: begin
                    acc_q  <= acc_d;
                    p_q    <= p_d;
                    step_q <= step_q + 4'd1;
                    if (last_step) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        det_q   <= det_d;
                        ovf_q   <= ovf_d;
                        erro_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    if (start) begin
                        for (int k = 0; k < 9; k++) elem_q[k] <= elem_in[k];
                        is3_q  <= size_3;
                        acc_q  <= '0;
                        p_q    <= '0;
                        step_q <= '0;
                        if (size_ok) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            erro_q  <= 1'b1;
                            det_q   <= '0;
                            ovf_q   <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign det           = det_q;
    assign overflow_flag = ovf_q;
    assign erro          = erro_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_controle_determinante.sv
// Bench for controle_determinante: cofactor-expansion reference model checked every cycle,
// plus directed vectors with hand-computed results.
`timescale 1ns/1ps
module tb_controle_determinante;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [199:0] matriz = '0;
    logic [1:0]   tamanho_matriz = 2'b00;
    logic         busy, done, overflow_flag, erro;
    logic [7:0]   det;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

`ifdef DET_SATURATE_EN
    localparam int W_POS = 127;
    localparam int W_NEG = -128;
`else
    localparam int W_POS = -108;
    localparam int W_NEG = -32;
`endif

    controle_determinante dut (
        .clk(clk), .rst_n(rst_n), .start(start), .matriz(matriz),
        .tamanho_matriz(tamanho_matriz), .busy(busy), .done(done), .det(det),
        .overflow_flag(overflow_flag), .erro(erro), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [199:0] pack3(input int v[9]);
        logic [199:0] m = '0;
        for (int k = 0; k < 9; k++) m[(8 - k)*8 +: 8] = 8'(v[k]);
        return m;
    endfunction

    function automatic logic [199:0] pack2(input int a, input int b, input int c, input int d);
        logic [199:0] m = '0;
        m[31:24] = 8'(a); m[23:16] = 8'(b); m[15:8] = 8'(c); m[7:0] = 8'(d);
        return m;
    endfunction

    // Exact determinant by cofactor expansion on the packed bus.
    function automatic longint exact_det(input logic [199:0] m, input logic [1:0] sz);
        longint e[9];
        for (int k = 0; k < 9; k++) e[k] = longint'($signed(m[(8 - k)*8 +: 8]));
        if (sz == 2'b01)
            return e[0]*(e[4]*e[8] - e[5]*e[7]) - e[1]*(e[3]*e[8] - e[5]*e[6])
                 + e[2]*(e[3]*e[7] - e[4]*e[6]);
        return longint'($signed(m[31:24])) * longint'($signed(m[7:0]))
             - longint'($signed(m[23:16])) * longint'($signed(m[15:8]));
    endfunction

    function automatic logic [7:0] exp_det8(input longint x);
`ifdef DET_SATURATE_EN
        if (x > 127)  return 8'h7f;
        if (x < -128) return 8'h80;
`endif
        return x[7:0];
    endfunction

    // Model state: one pending request plus the held result outputs.
    logic       p_valid = 1'b0, p_err = 1'b0, p_ovf = 1'b0;
    int         p_n = 0, p_done_edge = 0;
    logic [7:0] p_det = '0, m_det = '0;
    logic       m_ovf = 1'b0, m_err = 1'b0;

    always @(negedge clk) begin
        logic   exp_done, exp_busy;
        longint x;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_det", det, 0);
            chk("rst_ovf", overflow_flag, 0);
            chk("rst_erro", erro, 0);
            p_valid = 1'b0;
            m_det = '0; m_ovf = 1'b0; m_err = 1'b0;
        end else begin
            exp_done = p_valid && (edge_cnt == p_done_edge);
            exp_busy = p_valid && !p_err && (edge_cnt >= p_n) && (edge_cnt < p_done_edge);
            if (exp_done) begin
                m_det = p_det; m_ovf = p_ovf; m_err = p_err;
            end
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("det", $signed(det), $signed(m_det));
            chk("overflow_flag", overflow_flag, m_ovf);
            chk("erro", erro, m_err);
            if (start && !exp_busy) begin
                x           = exact_det(matriz, tamanho_matriz);
                p_valid     = 1'b1;
                p_n         = edge_cnt + 1;
                p_err       = tamanho_matriz[1];
                p_done_edge = p_n + (p_err ? 0 : (tamanho_matriz == 2'b01 ? 12 : 2));
                p_det       = p_err ? 8'h00 : exp_det8(x);
                p_ovf       = !p_err && (x > 127 || x < -128);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [1:0] sz, input logic [199:0] m);
        start = 1'b1; tamanho_matriz = sz; matriz = m;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int k = 0; k < 25; k++) matriz[k*8 +: 8] = 8'($urandom);
        tamanho_matriz = 2'($urandom_range(0, 3));
    endtask

    int m_seq[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int m_neg[9] = '{-1, 2, 3, 4, 5, 6, 7, 8, 10};

    initial begin
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        chk("pin_2x2_4500", exact_det(pack2(100, 50, 30, 60), 2'b00), 4500);
        chk("pin_2x2_m20000", exact_det(pack2(-100, 100, 100, 100), 2'b00), -20000);
        chk("pin_3x3_zero", exact_det(pack3(m_seq), 2'b01), 0);
        chk("pin_3x3_m7", exact_det(pack3(m_neg), 2'b01), -7);
        chk("pin_2x2_10", exact_det(pack2(3, 1, 2, 4), 2'b00), 10);
        chk("pin_det8_pos", $signed(exp_det8(4500)), W_POS);

        req(2'b00, pack2(100, 50, 30, 60));
        idle(2);
        chk("wrap_done", done, 1);
        chk("wrap_det", $signed(det), W_POS);
        chk("wrap_ovf", overflow_flag, 1);
        idle(1);

        req(2'b00, pack2(-100, 100, 100, 100));
        idle(2);
        chk("neg_done", done, 1);
        chk("neg_det", $signed(det), W_NEG);
        chk("neg_ovf", overflow_flag, 1);
        idle(1);

        req(2'b01, pack3(m_seq));
        idle(12);
        chk("seq3_done", done, 1);
        chk("seq3_det", $signed(det), 0);
        chk("seq3_ovf", overflow_flag, 0);
        idle(1);

        req(2'b01, pack3(m_neg));
        idle(3);
        req(2'b00, pack2(9, 9, 9, 9));
        idle(8);
        chk("neg3_done", done, 1);
        chk("neg3_det", $signed(det), -7);
        req(2'b00, pack2(3, 1, 2, 4));
        idle(2);
        chk("b2b_done", done, 1);
        chk("b2b_det", $signed(det), 10);
        idle(1);

        req(2'b10, pack3(m_seq));
        chk("err_done", done, 1);
        chk("err_erro", erro, 1);
        chk("err_det", $signed(det), 0);
        chk("err_busy", busy, 0);
        req(2'b00, pack2(3, 1, 2, 4));
        idle(2);
        chk("err_clear", erro, 0);
        chk("err_next_det", $signed(det), 10);
        idle(1);

        req(2'b01, pack3(m_neg));
        idle(4);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_det", $signed(det), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        req(2'b00, pack2(100, 50, 30, 60));
        idle(2);
        chk("post_rst_det", $signed(det), W_POS);
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
